// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - one-outstanding sram-port arbiter between fetch and data requesters
// Data has fixed priority; fetch wins after STARVE_LIMIT consecutive data grants it lost.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        inst_cancel,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state;
  logic          owner;
  logic          cancelled;
  logic [CW-1:0] starve_cnt;
  logic          starved;
  logic          grant_inst;
  logic          grant_data;
  logic          in_idle;
  logic          done;

  always_comb begin
    starved    = (starve_cnt == CW'(STARVE_LIMIT));
    grant_inst = inst_req && (!data_req || starved);
    grant_data = data_req && (!inst_req || !starved);
    in_idle    = (state == IDLE) && !reset;
    done       = (state == WAIT) && m_data_ok && !reset;
  end

  assign inst_addr_ok = in_idle && grant_inst;
  assign data_addr_ok = in_idle && grant_data;
  // A fetch flushed at any point after acceptance, including the completion cycle, is swallowed
  assign inst_data_ok = done && !owner && !cancelled && !inst_cancel;
  assign data_data_ok = done && owner;
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;
  assign m_req        = (state == ISSUE) && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      cancelled  <= 1'b0;
      starve_cnt <= '0;
      m_wr       <= 1'b0;
      m_size     <= 2'd0;
      m_wstrb    <= 4'd0;
      m_addr     <= 32'd0;
      m_wdata    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_inst || grant_data) begin
            state     <= ISSUE;
            owner     <= grant_data;
            cancelled <= 1'b0;
            m_wr      <= grant_data ? data_wr    : inst_wr;
            m_size    <= grant_data ? data_size  : inst_size;
            m_wstrb   <= grant_data ? data_wstrb : inst_wstrb;
            m_addr    <= grant_data ? data_addr  : inst_addr;
            m_wdata   <= grant_data ? data_wdata : inst_wdata;
            if (grant_inst || !inst_req)
              starve_cnt <= '0;
            else if (!starved)
              starve_cnt <= starve_cnt + CW'(1);
          end
        end
        ISSUE: begin
          if (m_addr_ok) state <= WAIT;
          if (!owner && inst_cancel) cancelled <= 1'b1;
        end
        WAIT: begin
          if (m_data_ok) state <= IDLE;
          if (!owner && inst_cancel) cancelled <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
// Stimulus pushes expected grants, bus payloads and completions; a negedge monitor pops and compares.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, inst_cancel;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .inst_cancel(inst_cancel),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  typedef struct packed {
    logic        owner;
    logic [31:0] rdata;
  } done_t;

  bit    exp_grant[$];
  bus_t  exp_bus[$];
  done_t exp_done[$];

  int n_chk = 0;
  int n_fail = 0;
  int cur_len = 0;
  int last_len = 0;

  int slv_adelay = 0;
  int slv_ddelay = 0;
  bit slv_en = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return (a == 32'h1c00_0010) ? 32'h1234_5678 : (a ^ 32'hFFFF_0000);
  endfunction

  // Slave: address accepted after slv_adelay waiting cycles, completion slv_ddelay cycles later
  initial begin
    int   cnt;
    int   ph;
    logic [31:0] sa;
    cnt = 0; ph = 0; sa = '0;
    m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (slv_en) begin
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
        if (reset) begin
          ph = 0; cnt = 0;
        end else if (ph == 0) begin
          if (m_req) begin
            if (cnt >= slv_adelay) begin
              m_addr_ok = 1'b1; sa = m_addr; cnt = 0; ph = 1;
            end else cnt++;
          end
        end else begin
          if (cnt >= slv_ddelay) begin
            m_data_ok = 1'b1; m_rdata = rdata_of(sa); cnt = 0; ph = 0;
          end else cnt++;
        end
      end else begin
        ph = 0; cnt = 0;
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (inst_addr_ok || data_addr_ok) begin
        chk("addr_ok_onehot", {30'd0, inst_addr_ok, data_addr_ok} == 32'd3 ? 32'd1 : 32'd0, 32'd0);
        if (exp_grant.size() == 0) chk("grant_unexpected", {31'd0, data_addr_ok}, 32'hFFFF_FFFF);
        else chk("grant_side", {31'd0, data_addr_ok}, {31'd0, exp_grant.pop_front()});
      end
      if (m_req) begin
        cur_len++;
        if (exp_bus.size() == 0) chk("m_req_unexpected", m_addr, 32'hFFFF_FFFF);
        else begin
          chk("bus_addr", m_addr, exp_bus[0].addr);
          chk("bus_wdata", m_wdata, exp_bus[0].wdata);
          chk("bus_ctl", {25'd0, m_wr, m_size, m_wstrb},
              {25'd0, exp_bus[0].wr, exp_bus[0].size, exp_bus[0].wstrb});
          if (m_addr_ok) begin
            void'(exp_bus.pop_front());
            last_len = cur_len;
            cur_len = 0;
          end
        end
      end
      if (inst_data_ok || data_data_ok) begin
        chk("data_ok_onehot", {31'd0, inst_data_ok && data_data_ok}, 32'd0);
        if (exp_done.size() == 0) chk("data_ok_unexpected", {31'd0, data_data_ok}, 32'hFFFF_FFFF);
        else begin
          done_t d;
          d = exp_done.pop_front();
          chk("done_owner", {31'd0, data_data_ok}, {31'd0, d.owner});
          chk("done_rdata", data_data_ok ? data_rdata : inst_rdata, d.rdata);
        end
      end
    end
  end

  task automatic issue(input bit side, input bit wr, input logic [1:0] sz, input logic [3:0] st,
                       input logic [31:0] a, input logic [31:0] wd, input bit expect_done);
    int t;
    exp_grant.push_back(side);
    exp_bus.push_back('{wr: wr, size: sz, wstrb: st, addr: a, wdata: wd});
    if (expect_done) exp_done.push_back('{owner: side, rdata: rdata_of(a)});
    @(posedge clk); #1;
    if (side) begin
      data_req = 1'b1; data_wr = wr; data_size = sz; data_wstrb = st; data_addr = a; data_wdata = wd;
    end else begin
      inst_req = 1'b1; inst_wr = wr; inst_size = sz; inst_wstrb = st; inst_addr = a; inst_wdata = wd;
    end
    t = 0;
    do begin @(negedge clk); t++; end
    while (!(side ? data_addr_ok : inst_addr_ok) && t < 50);
    chk("issue_timeout", {31'd0, t < 50}, 32'd1);
    @(posedge clk); #1;
    if (side) data_req = 1'b0; else inst_req = 1'b0;
  endtask

  task automatic wait_addr_ok();
    int t;
    t = 0;
    do begin @(negedge clk); t++; end
    while (!m_addr_ok && t < 50);
    chk("m_addr_ok_timeout", {31'd0, t < 50}, 32'd1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_done.size() != 0 || exp_bus.size() != 0 || exp_grant.size() != 0) && t < 200) begin
      @(negedge clk); t++;
    end
    chk("drain_timeout", {31'd0, t < 200}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bit ord [10];
    int t;
    int g;
    ord = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    reset = 1'b1; inst_cancel = 1'b0;
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_wstrb = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 1; data_wr = 0; data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;

    // Reset state, with a request held to prove addr_ok is forced low
    #12;
    chk("rst_m_req", {31'd0, m_req}, 32'd0);
    chk("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
    chk("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_ctl", {25'd0, m_wr, m_size, m_wstrb}, 32'd0);
    data_req = 1'b0;
    @(posedge clk); #1 reset = 1'b0;

    // Ideal-slave latency: accept t, m_req t+1, data_ok t+2
    exp_grant.push_back(1'b1);
    exp_bus.push_back('{wr: 1'b0, size: 2'd2, wstrb: 4'd0, addr: 32'h1c00_0010, wdata: 32'd0});
    exp_done.push_back('{owner: 1'b1, rdata: 32'h1234_5678});
    @(posedge clk); #1;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'd0;
    data_addr = 32'h1c00_0010; data_wdata = 32'd0;
    @(negedge clk);
    chk("lat_addr_ok_t", {31'd0, data_addr_ok}, 32'd1);
    @(posedge clk); #1 data_req = 1'b0;
    @(negedge clk);
    chk("lat_m_req_t1", {31'd0, m_req}, 32'd1);
    chk("lat_m_addr_t1", m_addr, 32'h1c00_0010);
    @(negedge clk);
    chk("lat_data_ok_t2", {31'd0, data_data_ok}, 32'd1);
    chk("lat_rdata_t2", data_rdata, 32'h1234_5678);
    chk("lat_inst_quiet", {31'd0, inst_data_ok}, 32'd0);
    drain();

    // Both sides continuously requesting: D,D,D,D,I,D,D,D,D,I
    for (int i = 0; i < 10; i++) begin
      exp_grant.push_back(ord[i]);
      exp_bus.push_back('{wr: 1'b0, size: 2'd2, wstrb: 4'd0,
                          addr: ord[i] ? 32'h0000_0200 : 32'h0000_0100, wdata: 32'd0});
      exp_done.push_back('{owner: ord[i], rdata: rdata_of(ord[i] ? 32'h0000_0200 : 32'h0000_0100)});
    end
    @(posedge clk); #1;
    inst_req = 1; inst_wr = 0; inst_size = 2; inst_wstrb = 0; inst_addr = 32'h100; inst_wdata = 0;
    data_req = 1; data_wr = 0; data_size = 2; data_wstrb = 0; data_addr = 32'h200; data_wdata = 0;
    g = 0; t = 0;
    while (g < 10 && t < 200) begin
      @(negedge clk); t++;
      if (inst_addr_ok || data_addr_ok) g++;
    end
    chk("starve_grants_timeout", {31'd0, t < 200}, 32'd1);
    @(posedge clk); #1 inst_req = 1'b0; data_req = 1'b0;
    drain();

    // Byte write with addr_ok held off: m_req for 3 cycles, stable payload, one data_ok
    slv_adelay = 2;
    issue(1'b1, 1'b1, 2'd0, 4'b0100, 32'h0000_0042, 32'h00AB_0000, 1'b1);
    drain();
    chk("mreq_hold_cycles", last_len, 32'd3);
    slv_adelay = 0;

    // Cancel pulsed in WAIT swallows the completion; next fetch completes
    slv_ddelay = 2;
    issue(1'b0, 1'b0, 2'd2, 4'd0, 32'h0000_0300, 32'd0, 1'b0);
    wait_addr_ok();
    @(posedge clk); #1 inst_cancel = 1'b1;
    @(posedge clk); #1 inst_cancel = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!m_data_ok && t < 20);
    chk("cancel_dataok_timeout", {31'd0, t < 20}, 32'd1);
    chk("cancel_wait_no_ok", {31'd0, inst_data_ok}, 32'd0);
    slv_ddelay = 0;
    drain();
    issue(1'b0, 1'b0, 2'd2, 4'd0, 32'h0000_0304, 32'd0, 1'b1);
    drain();

    // Cancel coincident with m_data_ok
    issue(1'b0, 1'b0, 2'd2, 4'd0, 32'h0000_0308, 32'd0, 1'b0);
    wait_addr_ok();
    @(posedge clk); #1 inst_cancel = 1'b1;
    @(negedge clk);
    chk("cancel_same_m_data_ok", {31'd0, m_data_ok}, 32'd1);
    chk("cancel_same_no_ok", {31'd0, inst_data_ok}, 32'd0);
    @(posedge clk); #1 inst_cancel = 1'b0;
    drain();

    // Reset in WAIT, then a stray slave response
    slv_ddelay = 3;
    issue(1'b1, 1'b0, 2'd2, 4'd0, 32'h0000_0400, 32'd0, 1'b0);
    wait_addr_ok();
    @(posedge clk); #3;
    slv_en = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
    reset = 1'b1; data_req = 1'b1;
    #1;
    chk("rstw_m_req", {31'd0, m_req}, 32'd0);
    chk("rstw_m_addr", m_addr, 32'd0);
    chk("rstw_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
    chk("rstw_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    exp_done.delete();
    @(posedge clk); @(posedge clk); #1;
    data_req = 1'b0; reset = 1'b0;
    @(posedge clk); #1 m_data_ok = 1'b1; m_addr_ok = 1'b1;
    @(negedge clk);
    chk("stray_no_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    chk("stray_no_m_req", {31'd0, m_req}, 32'd0);
    @(posedge clk); #1 m_data_ok = 1'b0; m_addr_ok = 1'b0; slv_en = 1'b1; slv_ddelay = 0;
    issue(1'b1, 1'b1, 2'd2, 4'hF, 32'h0000_0500, 32'hDEAD_BEEF, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
